// File: rtl/product_accumulator.sv
// Product accumulator: sums a packet of multiplier products (signed or
// unsigned) into a guarded accumulator, tracks sticky overflow and a
// saturating beat count, and presents one result per packet through a
// single-entry valid/ready output register.
module product_accumulator #(
  parameter int n  = 8,
  parameter int g  = 4,
  parameter int cw = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [2*n-1:0]       up_data,
  input  logic                 up_signed,
  input  logic                 up_last,
  output logic                 down_valid,
  input  logic                 down_ready,
  output logic [2*n+g-1:0]     down_data,
  output logic                 down_overflow,
  output logic [cw-1:0]        down_count
);

  localparam int W = 2*n + g;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACC  = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          ovf_q, ovf_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic          mode_q, mode_d;

  logic          dv_q, dv_d;
  logic [W-1:0]  dd_q, dd_d;
  logic          dovf_q, dovf_d;
  logic [cw-1:0] dcnt_q, dcnt_d;

  logic          accept;
  logic          mode_eff;
  logic [W-1:0]  ext;
  logic [W:0]    sum_full;
  logic [W-1:0]  sum_new;
  logic          ovf_add;
  logic [cw-1:0] cnt_new;

  // The output register frees up when empty or being drained this cycle;
  // up_valid never feeds back into up_ready.
  assign up_ready = ~dv_q | down_ready;
  assign accept   = up_valid & up_ready;

  // Mode comes from the beat itself at the start of a packet, else from the latch.
  assign mode_eff = (state_q == IDLE) ? up_signed : mode_q;

  // Extend the product, add it, and derive per-addition overflow and the next count.
  always_comb begin
    ext      = mode_eff ? {{g{up_data[2*n-1]}}, up_data} : {{g{1'b0}}, up_data};
    sum_full = {1'b0, sum_q} + {1'b0, ext};
    sum_new  = sum_full[W-1:0];
    if (mode_eff) begin
      ovf_add = (sum_q[W-1] == ext[W-1]) && (sum_new[W-1] != sum_q[W-1]);
    end else begin
      ovf_add = sum_full[W];
    end
    cnt_new = (cnt_q == {cw{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  end

  // Next-state for the packet accumulator, control FSM and output register.
  always_comb begin
    // NOTE: every target gets a default here so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    dv_d    = dv_q;
    dd_d    = dd_q;
    dovf_d  = dovf_q;
    dcnt_d  = dcnt_q;

    if (dv_q && down_ready) begin
      dv_d = 1'b0;
    end

    if (accept) begin
      if (up_last) begin
        dv_d    = 1'b1;
        dd_d    = sum_new;
        dovf_d  = ovf_q | ovf_add;
        dcnt_d  = cnt_new;
        state_d = IDLE;
        sum_d   = '0;
        ovf_d   = 1'b0;
        cnt_d   = '0;
        mode_d  = 1'b0;
      end else begin
        state_d = ACC;
        sum_d   = sum_new;
        ovf_d   = ovf_q | ovf_add;
        cnt_d   = cnt_new;
        mode_d  = mode_eff;
      end
    end
  end

  // State registers; reset discards any partial packet and any held result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      dv_q    <= 1'b0;
      dd_q    <= '0;
      dovf_q  <= 1'b0;
      dcnt_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      dv_q    <= dv_d;
      dd_q    <= dd_d;
      dovf_q  <= dovf_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign down_valid    = dv_q;
  assign down_data     = dd_q;
  assign down_overflow = dovf_q;
  assign down_count    = dcnt_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator: directed packets with known sums plus
// randomized packets under random backpressure, checked by a scoreboard fed
// from an arithmetic reference model.
module tb_product_accumulator;

  localparam int N  = 8;
  localparam int G  = 4;
  localparam int CW = 8;
  localparam int W  = 2*N + G;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_valid;
  logic          up_ready;
  logic [2*N-1:0] up_data;
  logic          up_signed;
  logic          up_last;
  logic          down_valid;
  logic          down_ready;
  logic [W-1:0]  down_data;
  logic          down_overflow;
  logic [CW-1:0] down_count;

  product_accumulator #(.n(N), .g(G), .cw(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .up_valid      (up_valid),
    .up_ready      (up_ready),
    .up_data       (up_data),
    .up_signed     (up_signed),
    .up_last       (up_last),
    .down_valid    (down_valid),
    .down_ready    (down_ready),
    .down_data     (down_data),
    .down_overflow (down_overflow),
    .down_count    (down_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic          ovf;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  rand_mode = 1'b0;

  // Reference model state: sum held as a plain non-negative integer below 2^W.
  longint m_sum;
  bit     m_mode;
  bit     m_ovf;
  int     m_cnt;
  bit     in_pkt = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    in_pkt = 1'b0;
  endfunction

  function automatic void model_beat(input logic [15:0] d, input logic s, input logic l);
    longint p, a, t;
    longint full  = 64'sd1 << W;
    longint half  = 64'sd1 << (W-1);
    exp_t   e;
    if (!in_pkt) begin
      in_pkt = 1'b1;
      m_mode = s;
      m_sum  = 0;
      m_ovf  = 1'b0;
      m_cnt  = 0;
    end
    if (m_mode) begin
      p = (d >= 16'h8000) ? longint'(d) - 65536 : longint'(d);
      a = (m_sum >= half) ? m_sum - full : m_sum;
      t = a + p;
      if (t > half - 1 || t < -half) m_ovf = 1'b1;
    end else begin
      p = longint'(d);
      t = m_sum + p;
      if (t >= full) m_ovf = 1'b1;
    end
    m_sum = t & (full - 1);
    m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
    if (l) begin
      e.data = m_sum[W-1:0];
      e.ovf  = m_ovf;
      e.cnt  = m_cnt[CW-1:0];
      sb_q.push_back(e);
      in_pkt = 1'b0;
    end
  endfunction

  // Offer one beat until accepted (bounded); returns at posedge+1.
  task automatic send_beat(input logic [15:0] d, input logic s, input logic l);
    bit acc = 1'b0;
    up_valid  = 1'b1;
    up_data   = d;
    up_signed = s;
    up_last   = l;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = up_ready;
      @(posedge clk);
      #1;
    end
    if (acc) model_beat(d, s, l);
    else check("accept_timeout", 64'd0, 64'd1);
    up_valid = 1'b0;
    up_last  = 1'b0;
  endtask

  task automatic check_out(input string name, input logic [W-1:0] d, input logic o, input logic [CW-1:0] c);
    check({name, "_valid"}, 64'(down_valid), 64'd1);
    check({name, "_data"},  64'(down_data),  64'(d));
    check({name, "_ovf"},   64'(down_overflow), 64'(o));
    check({name, "_count"}, 64'(down_count), 64'(c));
  endtask

  // Monitor: every consumed result is compared with the oldest expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && down_valid && down_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_result", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("sb_data",  64'(down_data),     64'(e.data));
          check("sb_ovf",   64'(down_overflow), 64'(e.ovf));
          check("sb_count", 64'(down_count),    64'(e.cnt));
        end
      end
    end
  end

  // Random consumer backpressure, changed just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) down_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    int len;

    rst        = 1'b0;
    up_valid   = 1'b0;
    up_data    = '0;
    up_signed  = 1'b0;
    up_last    = 1'b0;
    down_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 64'(down_valid), 64'd0);
    check("reset_data",  64'(down_data),  64'd0);
    check("reset_ovf",   64'(down_overflow), 64'd0);
    check("reset_count", 64'(down_count), 64'd0);
    check("reset_ready", 64'(up_ready),   64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Unsigned three-beat packet; result one cycle after last acceptance.
    send_beat(16'hFFFF, 1'b0, 1'b0);
    send_beat(16'hFFFF, 1'b0, 1'b0);
    send_beat(16'hFFFF, 1'b0, 1'b1);
    check_out("unsigned3", 20'h2FFFD, 1'b0, 8'd3);

    // Signed packet, then same beats with unsigned mode latched on beat one.
    send_beat(16'hFFFF, 1'b1, 1'b0);
    send_beat(16'h0002, 1'b1, 1'b1);
    check_out("signed2", 20'h00001, 1'b0, 8'd2);
    send_beat(16'hFFFF, 1'b0, 1'b0);
    send_beat(16'h0002, 1'b1, 1'b1);
    check_out("mode_latch", 20'h10001, 1'b0, 8'd2);

    // Unsigned and signed overflow.
    for (int i = 0; i < 17; i++) send_beat(16'hFFFF, 1'b0, i == 16);
    check_out("uovf", 20'h0FFEF, 1'b1, 8'd17);
    for (int i = 0; i < 17; i++) send_beat(16'h7FFF, 1'b1, i == 16);
    check_out("sovf", 20'h87FEF, 1'b1, 8'd17);

    // Beat counter saturation.
    for (int i = 0; i < 300; i++) send_beat(16'h0001, 1'b0, i == 299);
    check_out("saturate", 20'h0012C, 1'b0, 8'd255);

    // Backpressure: held result blocks input, then back-to-back reload.
    @(posedge clk);
    #1;
    down_ready = 1'b0;
    send_beat(16'h0003, 1'b0, 1'b1);
    up_valid  = 1'b1;
    up_data   = 16'h0007;
    up_signed = 1'b0;
    up_last   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ready", 64'(up_ready), 64'd0);
      check("bp_hold_data", 64'(down_data), 64'h3);
      check("bp_hold_valid", 64'(down_valid), 64'd1);
      check("bp_hold_count", 64'(down_count), 64'd1);
    end
    @(posedge clk);
    #1;
    down_ready = 1'b1;
    send_beat(16'h0007, 1'b0, 1'b1);
    check_out("b2b", 20'h00007, 1'b0, 8'd1);
    @(posedge clk);
    #1;

    // Reset mid-packet discards the partial sum.
    send_beat(16'h0100, 1'b0, 1'b0);
    send_beat(16'h0100, 1'b0, 1'b0);
    rst = 1'b0;
    #2;
    check("midrst_valid", 64'(down_valid), 64'd0);
    check("midrst_data",  64'(down_data),  64'd0);
    model_reset();
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_beat(16'h0005, 1'b0, 1'b1);
    check_out("after_rst", 20'h00005, 1'b0, 8'd1);

    // Randomized packets under random backpressure.
    rand_mode = 1'b1;
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 12);
      for (int b = 0; b < len; b++) begin
        case ($urandom_range(0, 5))
          0:       d = 16'hFFFF;
          1:       d = 16'h7FFF;
          2:       d = 16'h8000;
          default: d = 16'($urandom);
        endcase
        send_beat(d, 1'($urandom), b == len - 1);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    @(posedge clk);
    #1;
    rand_mode  = 1'b0;
    down_ready = 1'b1;
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 The block SHALL have parameter n, default 8, giving the multiplier operand width; incoming products are 2n bits wide.
REQ-002 The block SHALL have parameter g, default 4, giving the guard bits; the accumulator width is W = 2n+g.
REQ-003 The block SHALL have parameter cw, default 8, giving the beat-counter width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port up_valid, input, 1 bit: an upstream product beat is offered.
REQ-007 The block SHALL have port up_ready, output, 1 bit: the block accepts the offered beat this cycle.
REQ-008 The block SHALL have port up_data, input, 2n bits: the multiplier product.
REQ-009 The block SHALL have port up_signed, input, 1 bit: 1 means up_data is a two's-complement product, 0 means unsigned.
REQ-010 The block SHALL have port up_last, input, 1 bit: the final beat of the packet.
REQ-011 The block SHALL have port down_valid, output, 1 bit: a packet result is held.
REQ-012 The block SHALL have port down_ready, input, 1 bit: the consumer takes the result.
REQ-013 The block SHALL have port down_data, output, W bits: the accumulated sum.
REQ-014 The block SHALL have port down_overflow, output, 1 bit: the sum exceeded the W-bit range at some point in the packet.
REQ-015 The block SHALL have port down_count, output, cw bits: the number of beats in the packet, saturating.

Function
REQ-016 A beat SHALL be accepted exactly when up_valid and up_ready are both 1.
REQ-017 A result SHALL be consumed exactly when down_valid and down_ready are both 1.
REQ-018 up_ready SHALL equal (not down_valid) or down_ready, with no combinational path from up_valid.
REQ-019 Packet mode SHALL be latched from up_signed on the first accepted beat of each packet; up_signed on later beats SHALL be ignored.
REQ-020 Each accepted product SHALL be extended to W bits: sign-extended in signed mode, zero-extended in unsigned mode.
REQ-021 Each accepted product SHALL be added modulo 2^W to the running sum.
REQ-022 Overflow SHALL be detected per addition:
- signed mode: both operands have equal sign and the sum's sign differs;
- unsigned mode: carry out of bit W-1.
REQ-023 The overflow flag SHALL be sticky for the rest of the packet.
REQ-024 The beat counter SHALL increment on each accepted beat and saturate at 2^cw-1.
REQ-025 On an accepted beat with up_last=1, the following SHALL be registered into the output in the same edge: the final sum (including that beat), the final overflow flag and the final count; down_valid SHALL then be 1.
REQ-026 Latency SHALL be one cycle from acceptance of the last beat to down_valid=1.
REQ-027 On the same edge as REQ-025, the internal sum, flag, counter and mode SHALL clear, so the next beat starts a new packet.
REQ-028 A single-beat packet SHALL produce down_data equal to the extended product and down_count=1.
REQ-029 down_valid SHALL clear on consumption unless a new last beat is accepted on the same edge, in which case the new result SHALL load and down_valid SHALL stay 1.
REQ-030 While down_valid=1 and down_ready=0, the outputs and the internal state SHALL hold, and no beat SHALL be accepted.
REQ-031 Non-last beats SHALL be accepted while an earlier result is still held, as long as up_ready=1.
REQ-032 The control SHALL be a two-state machine:
- IDLE (no partial packet): moves to ACC on an accepted non-last beat;
- ACC: moves to IDLE on an accepted last beat.

Reset
REQ-033 rst=0 SHALL, asynchronously, force the following: down_valid=0, down_data=0, down_overflow=0, down_count=0, internal sum/flag/counter/mode=0, and state IDLE.
REQ-034 A partial packet in progress at reset SHALL be discarded.
REQ-035 Release of reset SHALL be treated as synchronous to clk, and the first accepted beat after release SHALL start a new packet.

Verification (n=8, g=4, W=20, cw=8, down_ready=1 unless stated)
REQ-036 Unsigned: 3 beats of 16'hFFFF, up_signed=0, last on the third -> down_data=20'h2FFFD, overflow=0, count=3, one cycle after the third acceptance.
REQ-037 Signed: beats 16'hFFFF then 16'h0002 (last), up_signed=1 -> down_data=20'h00001, overflow=0, count=2; the same beats with the first beat at up_signed=0 -> 20'h10001.
REQ-038 Unsigned overflow: 17 beats of 16'hFFFF -> down_data=20'h0FFEF, overflow=1, count=17.
REQ-039 Signed overflow: 17 beats of 16'h7FFF -> down_data=20'h87FEF, overflow=1.
REQ-040 Backpressure: result held with down_ready=0 and up_valid=1 for 5 cycles -> up_ready=0 and outputs stable; set down_ready=1 with a last beat offered -> back-to-back result, down_valid stays 1.
REQ-041 Reset mid-packet: 2 beats of 16'h0100, pulse rst low, then single beat 16'h0005 last -> down_data=20'h00005, count=1.
